issue_scheduler: RTL

Dual-issue in-order scheduler sitting between the instruction fetch stage and the two execute pipes. It accepts 32-bit RV32I instruction pairs from fetch into a small queue and tracks pending register writes in a per-register countdown scoreboard. Each cycle it issues zero, one or two instructions in program order, routing them to pipe 0 and pipe 1. It throttles fetch through a ready signal and reports completion once fetch has finished and all work has drained.

---
 rtl/issue_scheduler.sv | 99 +++++++++
 1 files changed

// File: rtl/issue_scheduler.sv
// issue_scheduler: dual-issue in-order scheduler with fetch queue and per-register countdown scoreboard
module issue_scheduler #(
  parameter int QDEPTH = 4,
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_instr1,
  input  logic [31:0] in_instr2,
  output logic        in_ready,
  input  logic        fetch_done,
  input  logic        flush,
  output logic        iss0_valid,
  output logic [31:0] iss0_instr,
  output logic        iss1_valid,
  output logic [31:0] iss1_instr,
  output logic        done,
  output logic [15:0] stall_cycles
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  logic [31:0] q [QDEPTH];
  logic [PW-1:0] hd, tl;
  logic [CW-1:0] count;
  logic [2:0] sb [1:31];
  logic [31:0] blk, h, s;
  logic ok0, ok1, go0, go1, idle, w1, w2;
  logic [1:0] n_iss, n_add;
  function automatic logic wr(input logic [31:0] i);
    return i[11:7] != 5'd0 && i[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
  endfunction
  function automatic logic r1(input logic [31:0] i);
    return !(i[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111});
  endfunction
  function automatic logic r2(input logic [31:0] i);
    return i[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
  endfunction
  function automatic logic ctl(input logic [31:0] i);
    return i[6:0] inside {7'b1100011, 7'b1101111, 7'b1100111};
  endfunction
  function automatic logic mem(input logic [31:0] i);
    return i[6:0] inside {7'b0000011, 7'b0100011};
  endfunction
  function automatic logic elig(input logic [31:0] i, input logic [31:0] b);
    return !(r1(i) && b[i[19:15]]) && !(r2(i) && b[i[24:20]]) && !(wr(i) && b[i[11:7]]);
  endfunction
  always_comb begin
    blk = '0;
    idle = 1'b1;
    for (int r = 1; r < 32; r++) begin
      blk[r] = sb[r] > 3'd1;
      idle = idle && sb[r] == 3'd0;
    end
  end
  assign h = q[hd];
  assign s = q[hd + PW'(1)];
  assign ok0 = count != '0 && elig(h, blk);
  assign ok1 = ok0 && count >= CW'(2) && !ctl(h) && elig(s, blk) && !(mem(h) && mem(s)) &&
               !(wr(h) && ((r1(s) && s[19:15] == h[11:7]) || (r2(s) && s[24:20] == h[11:7]) || (wr(s) && s[11:7] == h[11:7])));
  assign go0 = ok0 && !flush;
  assign go1 = ok1 && !flush;
  assign n_iss = {1'b0, go0} + {1'b0, go1};
  assign in_ready = count <= CW'(QDEPTH - 2);
  assign w1 = in_valid && in_ready && !flush && in_instr1 != 32'h0;
  assign w2 = in_valid && in_ready && !flush && in_instr2 != 32'h0;
  assign n_add = {1'b0, w1} + {1'b0, w2};
  always_ff @(posedge clk) begin
    if (w1) q[tl] <= in_instr1;
    if (w2) q[tl + PW'(w1)] <= in_instr2;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hd <= '0;
      tl <= '0;
      count <= '0;
      for (int r = 1; r < 32; r++) sb[r] <= '0;
      iss0_valid <= 1'b0;
      iss0_instr <= '0;
      iss1_valid <= 1'b0;
      iss1_instr <= '0;
      stall_cycles <= '0;
      done <= 1'b0;
    end else begin
      hd <= flush ? '0 : hd + PW'(n_iss);
      tl <= flush ? '0 : tl + PW'(n_add);
      count <= flush ? '0 : count + CW'(n_add) - CW'(n_iss);
      for (int r = 1; r < 32; r++)
        if ((go0 && wr(h) && h[11:7] == 5'(r)) || (go1 && wr(s) && s[11:7] == 5'(r))) sb[r] <= 3'(LAT);
        else if (sb[r] != 3'd0) sb[r] <= sb[r] - 3'd1;
      iss0_valid <= go0;
      iss0_instr <= go0 ? h : '0;
      iss1_valid <= go1;
      iss1_instr <= go1 ? s : '0;
      if (count != '0 && n_iss == 2'd0 && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
      done <= done || (fetch_done && count == '0 && idle);
    end
  end
endmodule
